sync_ff_bank: RTL

- Edge-triggered, WIDTH-bit storage bank; the clocked counterpart to the team's level-sensitive latch cells (SR/D/JK/T).
- One run-time mode register selects D, SR, JK or T next-state behaviour for all bits.
- Mode changes use a valid/ready handshake followed by a one-cycle hold state.
- SR forbidden inputs (S=R=1) are detected and reported through a sticky error flag instead of producing X.

---
 rtl/sync_ff_bank.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sync_ff_bank.sv
// Edge-triggered WIDTH-bit storage bank with run-time D/SR/JK/T mode; optional change counter via SYNC_FF_BANK_CHG_CNT_EN.
// Latency: one cycle from a_i/b_i/en_i to q_o; a mode handshake edge plus one HOLD cycle freeze q_o.
// Backpressure: cfg_ready_o drops for the HOLD cycle after a mode handshake; cfg_valid_i is ignored while it is low.
module sync_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cfg_valid_i,
  input  logic [1:0]       cfg_mode_i,
  output logic             cfg_ready_o,
  output logic [1:0]       mode_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             err_o,
  output logic [WIDTH-1:0] err_bits_o,
  input  logic             clr_err_i,
  output logic [15:0]      chg_cnt_o
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_SR = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state;
  logic             upd;
  logic [WIDTH-1:0] q_mode_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] err_set;

  // An enabled update only happens in RUN when no handshake is taking the edge.
  assign upd = (state == ST_RUN) && !cfg_valid_i && en_i;

  // Per-mode next state for every bit, written as bitwise equations.
  always_comb begin
    q_mode_nxt = q_o;
    case (mode_o)
      MODE_D:  q_mode_nxt = a_i;
      // Set on S&~R, clear on ~S&R, otherwise (including S=R=1) keep.
      MODE_SR: q_mode_nxt = (a_i & ~b_i) | (q_o & ~(a_i ^ b_i));
      MODE_JK: q_mode_nxt = (a_i & ~q_o) | (~b_i & q_o);
      MODE_T:  q_mode_nxt = q_o ^ a_i;
      default: q_mode_nxt = q_o;
    endcase
  end

  assign q_nxt   = upd ? q_mode_nxt : q_o;
  assign err_set = (upd && (mode_o == MODE_SR)) ? (a_i & b_i) : '0;
  assign qn_o    = ~q_o;

  // Mode FSM plus storage: a handshake claims the edge, then one HOLD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cfg_ready_o <= 1'b1;
      mode_o      <= MODE_D;
      q_o         <= RESET_VAL;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_valid_i) begin
            mode_o      <= cfg_mode_i;
            state       <= ST_HOLD;
            cfg_ready_o <= 1'b0;
          end else begin
            q_o <= q_nxt;
          end
        end
        ST_HOLD: begin
          state       <= ST_RUN;
          cfg_ready_o <= 1'b1;
        end
        default: begin
          state       <= ST_RUN;
          cfg_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Sticky SR-invalid flags; a clear drops old bits but keeps the ones set this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_bits_o <= '0;
    end else if (clr_err_i) begin
      err_o      <= |err_set;
      err_bits_o <= err_set;
    end else begin
      err_o      <= err_o | (|err_set);
      err_bits_o <= err_bits_o | err_set;
    end
  end

`ifdef SYNC_FF_BANK_CHG_CNT_EN
  logic [15:0] chg_cnt_r;

  // Saturating count of edges on which q_o takes a different value.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt_r <= '0;
    end else if ((q_nxt != q_o) && (chg_cnt_r != 16'hFFFF)) begin
      chg_cnt_r <= chg_cnt_r + 16'd1;
    end
  end

  assign chg_cnt_o = chg_cnt_r;
`else
  assign chg_cnt_o = 16'd0;
`endif

endmodule
